// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the fetch port and the
// MEM-stage port, one transaction at a time, alternating priority on
// contention.
//
// state  | meaning
// IDLE   | nothing in flight, waiting for any request
// ACCESS | RAM enabled for WAIT_CYCLES cycles from the latched request
// RESP   | one-cycle ready pulse to the owner; may grant the next request
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic       OWN_IF  = 1'b0;
  localparam logic       OWN_MEM = 1'b1;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        owner_q;
  logic        last_owner_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_ready_q;
  logic        mem_ready_q;
  logic        ram_en_q;
  logic        ram_we_q;

  logic        mem_any;
  logic        any_req;
  logic        grant_mem_d;

  assign mem_any = mem_rd | mem_wr;
  assign any_req = if_req | mem_any;

  // Arbitration: a lone requester wins; on contention the port that did not
  // own the previous grant wins, so continuous contention alternates.
  always_comb begin
    grant_mem_d = 1'b0;
    if (mem_any && (!if_req || (last_owner_q == OWN_IF))) begin
      grant_mem_d = 1'b1;
    end
  end

  // Transaction FSM with down-counter timing of the ACCESS phase; all RAM
  // and handshake outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      if_rdata_q   <= 32'd0;
      mem_rdata_q  <= 32'd0;
      if_ready_q   <= 1'b0;
      mem_ready_q  <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      unique case (state_q)
        IDLE, RESP: begin
          if (any_req) begin
            // Both read and write flags set is handled as a write.
            state_q      <= ACCESS;
            cnt_q        <= WAIT_LD;
            owner_q      <= grant_mem_d;
            last_owner_q <= grant_mem_d;
            we_q         <= grant_mem_d & mem_wr;
            addr_q       <= grant_mem_d ? mem_addr : if_addr;
            wdata_q      <= grant_mem_d ? mem_wdata : 32'd0;
            ram_en_q     <= 1'b1;
            ram_we_q     <= grant_mem_d & mem_wr;
          end else begin
            state_q  <= IDLE;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q  <= RESP;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            if (!we_q) begin
              if (owner_q == OWN_MEM) begin
                mem_rdata_q <= ram_rdata;
              end else begin
                if_rdata_q <= ram_rdata;
              end
            end
            if (owner_q == OWN_MEM) begin
              mem_ready_q <= 1'b1;
            end else begin
              if_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= 4'd0;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  // Stalls follow the live requests so a requester sees them drop in the
  // same cycle its ready pulse arrives.
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = mem_any & ~mem_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic against a transaction-level
// reference model; expected completions go into a queue that a separate
// monitor drains.
module tb_mem_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_ready, mem_ready, stall_if, stall_mem, ram_en, ram_we;

  logic        rst1 = 1'b1;
  logic        if_req1 = 1'b0;
  logic [31:0] if_rdata1, mem_rdata1, ram_addr1, ram_wdata1;
  logic        if_ready1, mem_ready1, stall_if1, stall_mem1, ram_en1, ram_we1;

  mem_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst1),
    .if_req(if_req1), .if_addr(32'h20), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .mem_rd(1'b0), .mem_wr(1'b0), .mem_addr(32'h0), .mem_wdata(32'h0),
    .mem_rdata(mem_rdata1), .mem_ready(mem_ready1),
    .stall_if(stall_if1), .stall_mem(stall_mem1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
    .ram_rdata(32'h5A5A0000)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i) * 32'h0101_0111);
  endfunction

  // RAM model seen by the DUT (written only by the monitor process)
  logic [31:0] ram [16];
  assign ram_rdata = ram[ram_addr[5:2]];

  // Reference model state (written only by the driver process)
  typedef struct {
    bit          own;   // 1 = MEM
    int          rc;    // cycle of the ready pulse
    logic [31:0] e_if;
    logic [31:0] e_mem;
  } exp_t;
  exp_t        expq[$];
  logic [31:0] ref_mem [16];
  int          acc_lo = -1, acc_hi = -2;
  bit          acc_we = 1'b0;
  logic [31:0] acc_a = 32'd0, acc_wd = 32'd0;
  int          next_free = 1 << 30;
  bit          last_own = 1'b0;
  logic [31:0] if_hold = 32'd0, mem_hold = 32'd0;

  bit          if_act = 1'b0, m_act = 1'b0, m_rd = 1'b0, m_wr = 1'b0;
  logic [31:0] if_a = 32'd0, m_a = 32'd0, m_wd = 32'd0;
  int          if_done = -1, m_done = -1;

  // Monitor: per-cycle checks of RAM side, stalls and ready/rdata.
  initial begin
    bit in_acc, rdy_if, rdy_mem;
    for (int i = 0; i < 16; i++) ram[i] = init_word(i);
    forever begin
      @(negedge clk);
      while (expq.size() > 0 && expq[0].rc < cyc) begin
        total++; bad++;
        $display("FAIL ready_missing: got none want ready at cycle %0d (now %0d)", expq[0].rc, cyc);
        void'(expq.pop_front());
      end
      rdy_if  = expq.size() > 0 && expq[0].rc == cyc && !expq[0].own;
      rdy_mem = expq.size() > 0 && expq[0].rc == cyc && expq[0].own;
      chk("stall_if", stall_if, if_req & !rdy_if);
      chk("stall_mem", stall_mem, (mem_rd | mem_wr) & !rdy_mem);
      if (rst) begin
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
      end else begin
        chk("if_ready", if_ready, rdy_if);
        chk("mem_ready", mem_ready, rdy_mem);
        if (rdy_if || rdy_mem) begin
          chk("if_rdata", if_rdata, expq[0].e_if);
          chk("mem_rdata", mem_rdata, expq[0].e_mem);
          void'(expq.pop_front());
        end
        in_acc = (cyc >= acc_lo) && (cyc <= acc_hi);
        chk("ram_en", ram_en, in_acc);
        chk("ram_we", ram_we, in_acc & acc_we);
        if (in_acc) chk("ram_addr", ram_addr, acc_a);
        if (in_acc && acc_we) chk("ram_wdata", ram_wdata, acc_wd);
      end
      if (ram_en && ram_we) ram[ram_addr[5:2]] = ram_wdata;
    end
  end

  task automatic grant(input int c);
    exp_t e;
    bit own;
    own = (if_act && m_act) ? (last_own == 1'b0) : m_act;
    last_own  = own;
    next_free = c + W + 1;
    acc_lo    = c + 1;
    acc_hi    = c + W;
    if (own) begin
      acc_a = m_a; acc_we = m_wr; acc_wd = m_wd; m_done = c + W + 1;
      if (m_wr) ref_mem[m_a[5:2]] = m_wd;
      else mem_hold = ref_mem[m_a[5:2]];
    end else begin
      acc_a = if_a; acc_we = 1'b0; if_done = c + W + 1;
      if_hold = ref_mem[if_a[5:2]];
    end
    e.own = own; e.rc = c + W + 1; e.e_if = if_hold; e.e_mem = mem_hold;
    expq.push_back(e);
  endtask

  task automatic issue_if(input logic [31:0] a);
    if_act = 1'b1; if_a = a;
  endtask

  task automatic issue_mem(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    m_act = 1'b1; m_rd = rd; m_wr = wr; m_a = a; m_wd = wd;
  endtask

  // One cycle: retire completed requests, optionally issue random ones,
  // drive the pins and let the model decide the grant at the coming edge.
  task automatic step(input int pct, input bit rst_v);
    int c;
    int k;
    @(negedge clk); #1;
    c = cyc;
    if (if_act && if_done == c) begin if_act = 1'b0; if_done = -1; end
    if (m_act && m_done == c) begin m_act = 1'b0; m_done = -1; end
    if (!if_act && pct > 0 && $urandom_range(1, 100) <= pct)
      issue_if($urandom & 32'hFFFF_FFFC);
    if (!m_act && pct > 0 && $urandom_range(1, 100) <= pct) begin
      k = $urandom_range(0, 2);
      issue_mem(k != 1, k != 0, $urandom & 32'hFFFF_FFFC, $urandom);
    end
    if (rst_v && !rst) begin
      while (expq.size() > 0 && expq[$].rc > c) void'(expq.pop_back());
      acc_hi = -2; if_done = -1; m_done = -1; last_own = 1'b0;
      if_hold = 32'd0; mem_hold = 32'd0; next_free = 1 << 30;
    end
    if (!rst_v && rst) next_free = c;
    rst       = rst_v;
    if_req    = if_act;
    if_addr   = if_act ? if_a : $urandom;
    mem_rd    = m_act & m_rd;
    mem_wr    = m_act & m_wr;
    mem_addr  = m_act ? m_a : $urandom;
    mem_wdata = m_act ? m_wd : $urandom;
    if (!rst && c >= next_free && (if_act || m_act)) grant(c);
  endtask

  // Second instance: WAIT_CYCLES=1 with a permanently held fetch request.
  initial begin
    int c1, r;
    bit rdy;
    if_req1 = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst1 = 1'b0;
    c1 = cyc;
    repeat (20) begin
      @(negedge clk);
      r = cyc - c1;
      rdy = (r >= 2) && (r % 2 == 0);
      chk("w1_if_ready", if_ready1, rdy);
      chk("w1_stall_if", stall_if1, !rdy);
      chk("w1_ram_en", ram_en1, r % 2 == 1);
      chk("w1_mem_ready", mem_ready1, 0);
      chk("w1_stall_mem", stall_mem1, 0);
      chk("w1_ram_we", ram_we1, 0);
      chk("w1_ram_wdata", ram_wdata1, 0);
      chk("w1_mem_rdata", mem_rdata1, 0);
      if (r % 2 == 1) chk("w1_ram_addr", ram_addr1, 32'h20);
      if (rdy) chk("w1_if_rdata", if_rdata1, 32'h5A5A0000);
    end
  end

  // Driver: directed scenarios, then random traffic.
  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    repeat (3) step(0, 1'b1);
    // fetch-only read right at reset release
    issue_if(32'h10);
    step(0, 1'b0);
    repeat (5) step(0, 1'b0);
    // simultaneous requests: MEM first, then IF back-to-back
    issue_mem(1'b1, 1'b0, 32'h40, 32'h0);
    issue_if(32'h10);
    repeat (9) step(0, 1'b0);
    // sustained contention
    repeat (14) step(100, 1'b0);
    repeat (6) step(0, 1'b0);
    // write carrying a read flag
    issue_mem(1'b1, 1'b1, 32'h8, 32'h1234);
    repeat (6) step(0, 1'b0);
    // reset in the first ACCESS cycle of a fetch read, request held
    issue_if(32'h8);
    step(0, 1'b0);
    step(0, 1'b1);
    step(0, 1'b0);
    repeat (6) step(0, 1'b0);
    // random traffic
    repeat (400) step(40, 1'b0);
    repeat (8) step(0, 1'b0);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
